// File: rtl/dac_cal_pipeline.sv
// Calibrated multi-channel DAC code pipeline: two-point per-channel
// calibration, rounded restoring division, saturation to DAC range.
module dac_cal_pipeline #(
  parameter int N            = 16,
  parameter int M            = 12,
  parameter int NCH          = 2,
  parameter int CHW          = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int FULL_SCALE   = 25000,
  parameter int DAC_ZERO_DEF = 2048,
  parameter int DAC_FS_DEF   = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [CHW-1:0] in_ch,
  input  logic [N-1:0]   in_volts,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CHW-1:0] out_ch,
  output logic [M-1:0]   out_word,
  output logic           out_sat,
  input  logic           cal_we,
  input  logic [CHW-1:0] cal_ch,
  input  logic           cal_sel,
  input  logic [M-1:0]   cal_data
);

  localparam int K  = N + M + 1;
  localparam int CW = $clog2(K);
  localparam logic [CW-1:0] KLAST = CW'(K - 1);
  localparam logic [K-1:0]  HALF  = K'(FULL_SCALE / 2);
  localparam logic [K:0]    FSW   = (K+1)'(FULL_SCALE);
  localparam logic signed [K+1:0] MAXC = (K+2)'((1 << M) - 1);

  typedef enum logic [2:0] {
    IDLE, MULT, DIV, ADJ, OUT
  } state_t;

  state_t state;

  logic [M-1:0]   zero_r [NCH];
  logic [M-1:0]   fs_r   [NCH];
  logic [M-1:0]   zsel, fsel;

  logic [CHW-1:0] s_ch;
  logic [N-1:0]   s_volts;
  logic [M-1:0]   s_zero, s_fs;
  logic           sgn;
  logic [K-1:0]   a_sh, rem, q;
  logic [CW-1:0]  cnt;

  logic signed [M:0]   slope;
  logic signed [K-1:0] slope_x, volts_x, prod;
  logic [K-1:0]        mag, a_in;
  logic [K:0]          rem_sh, diff;
  logic [K-1:0]        rem_nx;
  logic signed [K+1:0] dq, dd, r;
  logic                neg, hi;

  assign in_ready = (state == IDLE);

  always_comb begin
    zsel = zero_r[0];
    fsel = fs_r[0];
    for (int i = 0; i < NCH; i++) begin
      if (in_ch == CHW'(i)) begin
        zsel = zero_r[i];
        fsel = fs_r[i];
      end
    end
  end

  assign slope   = $signed({1'b0, s_fs}) - $signed({1'b0, s_zero});
  assign slope_x = {{(K-M-1){slope[M]}}, slope};
  assign volts_x = {{(K-N){s_volts[N-1]}}, s_volts};
  assign prod    = slope_x * volts_x;
  assign mag     = prod[K-1] ? -prod : prod;
  assign a_in    = mag + HALF;

  // Borrow out of the trial subtraction doubles as the quotient bit.
  assign rem_sh = {rem, a_sh[K-1]};
  assign diff   = rem_sh - FSW;
  assign rem_nx = diff[K] ? rem_sh[K-1:0] : diff[K-1:0];

  assign dq  = $signed({2'b00, q});
  assign dd  = sgn ? -dq : dq;
  assign r   = dd + $signed({{(K+2-M){1'b0}}, s_zero});
  assign neg = r[K+1];
  assign hi  = !neg && (r > MAXC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_ch    <= '0;
      out_sat   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        zero_r[i] <= M'(DAC_ZERO_DEF);
        fs_r[i]   <= M'(DAC_FS_DEF);
      end
    end else begin
      if (cal_we) begin
        for (int i = 0; i < NCH; i++) begin
          if (cal_ch == CHW'(i)) begin
            if (cal_sel) fs_r[i]   <= cal_data;
            else         zero_r[i] <= cal_data;
          end
        end
      end
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            s_ch    <= in_ch;
            s_volts <= in_volts;
            s_zero  <= zsel;
            s_fs    <= fsel;
            state   <= MULT;
          end
        end
        MULT: begin
          sgn   <= prod[K-1];
          a_sh  <= a_in;
          rem   <= '0;
          q     <= '0;
          cnt   <= '0;
          state <= DIV;
        end
        DIV: begin
          a_sh <= a_sh << 1;
          rem  <= rem_nx;
          q    <= {q[K-2:0], ~diff[K]};
          if (cnt == KLAST) state <= ADJ;
          else              cnt   <= cnt + 1'b1;
        end
        ADJ: begin
          out_ch    <= s_ch;
          out_sat   <= neg | hi;
          out_word  <= neg ? '0 : (hi ? '1 : r[M-1:0]);
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_cal_pipeline.sv
// Scoreboard bench for dac_cal_pipeline: directed samples with
// hand-computed codes, latency, back-pressure and reset checks.
module tb_dac_cal_pipeline;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [0:0]  in_ch;
  logic [15:0] in_volts;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  out_ch;
  logic [11:0] out_word;
  logic        out_sat;
  logic        cal_we;
  logic [0:0]  cal_ch;
  logic        cal_sel;
  logic [11:0] cal_data;

  dac_cal_pipeline dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .in_volts(in_volts),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_word(out_word), .out_sat(out_sat),
    .cal_we(cal_we), .cal_ch(cal_ch),
    .cal_sel(cal_sel), .cal_data(cal_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int word;
    int sat;
    int acc;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input int volts,
                      input int word, input int sat,
                      input bit push);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      bad++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
      return;
    end
    in_valid = 1'b1;
    in_ch    = 1'(ch);
    in_volts = 16'(volts);
    tick();
    in_valid = 1'b0;
    in_volts = 16'h5a5a;
    e.ch   = ch;
    e.word = word;
    e.sat  = sat;
    e.acc  = cyc;
    if (push) sbq.push_back(e);
  endtask

  task automatic cal_wr(input int ch, input int sel, input int data);
    cal_we   = 1'b1;
    cal_ch   = 1'(ch);
    cal_sel  = 1'(sel);
    cal_data = 12'(data);
    tick();
    cal_we = 1'b0;
  endtask

  // Monitor: latency checked at the rising edge of out_valid,
  // payload checked at the handshake.
  bit prev_valid = 1'b0;
  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (sbq.size() == 0) begin
          bad++;
          total++;
          $display("FAIL unexpected_out: got word %0d expected none",
                   out_word);
        end else begin
          chk("latency", cyc - sbq[0].acc, 31);
        end
      end
      if (out_valid && out_ready && sbq.size() != 0) begin
        exp_t e;
        e = sbq.pop_front();
        chk("out_ch", int'(out_ch), e.ch);
        chk("out_word", int'(out_word), e.word);
        chk("out_sat", int'(out_sat), e.sat);
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_ch     = '0;
    in_volts  = '0;
    out_ready = 1'b1;
    cal_we    = 1'b0;
    cal_ch    = '0;
    cal_sel   = 1'b0;
    cal_data  = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_word", int'(out_word), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_out_sat", int'(out_sat), 0);

    send(1, 25000, 1, 0, 1);
    cal_wr(0, 0, 2077);
    cal_wr(0, 1, 157);
    send(0, 25000, 157, 0, 1);
    send(0, 0, 2077, 0, 1);
    send(0, 12500, 1117, 0, 1);
    send(0, 13, 2076, 0, 1);
    send(0, -32768, 4095, 1, 1);
    send(0, 32767, 0, 1, 1);

    send(1, 25000, 1, 0, 1);
    repeat (10) tick();
    cal_wr(1, 0, 2073);
    cal_wr(1, 1, 146);
    send(1, 25000, 146, 0, 1);

    // Back-pressure: hold the result and offer a new sample meanwhile.
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    send(0, 0, 2077, 0, 1);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("hold_reached", int'(out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_ch    = 1'b1;
      in_volts = 16'd1000;
      tick();
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_word", int'(out_word), 2077);
      chk("hold_ch", int'(out_ch), 0);
      chk("hold_sat", int'(out_sat), 0);
      chk("hold_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("release_idle", int'(in_ready), 1);
    chk("release_valid", int'(out_valid), 0);
    repeat (40) tick();

    // Reset mid-divide drops the sample and restores default cal.
    send(0, 12500, 0, 0, 0);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    repeat (40) tick();
    send(0, 25000, 1, 0, 1);
    send(1, 25000, 1, 0, 1);

    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain", sbq.size(), 0);
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
